// File: rtl/agc_power_peak_detect.sv
// rtl/agc_power_peak_detect.sv - I/Q instantaneous power peak/mean detector feeding the AGC loop
//
// Purpose:
//   Squares signed baseband I/Q samples, tracks the peak (and optionally the mean)
//   of I^2+Q^2 over windows of 2**WIN_LOG2 valid samples, and presents the result
//   with a one-cycle strobe when each window closes. Latency from sample to the
//   processing of that sample is 3 clocks.
//
// Optional feature macro: AGC_MEAN_POWER_EN
//   defined     - 48-bit sum accumulator, o_power_mean = window sum >> WIN_LOG2
//   not defined - no accumulator, o_power_mean tied to zero
//
// Ports:
//   i_clk          working clock
//   i_rst          asynchronous reset, active-high
//   i_clr          synchronous clear: abort current window and restart
//   i_data_vld     I/Q sample valid, one sample per high cycle
//   i_data_i       signed I sample
//   i_data_q       signed Q sample
//   o_power_peak   max I^2+Q^2 of last completed window, held between strobes
//   o_power_mean   mean I^2+Q^2 of last completed window
//   o_abs_ena      one-cycle strobe, peak/mean updated this cycle
//   o_win_cnt      valid samples accumulated in current window

module agc_power_peak_detect #(
   parameter int WIN_LOG2 = 10,
   parameter int DW       = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clr,
   input  logic                 i_data_vld,
   input  logic signed [DW-1:0] i_data_i,
   input  logic signed [DW-1:0] i_data_q,
   output logic [31:0]          o_power_peak,
   output logic [31:0]          o_power_mean,
   output logic                 o_abs_ena,
   output logic [15:0]          o_win_cnt
);

   localparam logic [WIN_LOG2-1:0] CNT_MAX = '1;

   typedef enum logic {S_IDLE, S_ACC} state_t;

   state_t               r_state;
   state_t               w_state_n;
   logic                 w_close;

   logic                 r_vld0, r_vld1, r_vld2;
   logic signed [DW-1:0] r_i, r_q;
   logic [30:0]          r_i2, r_q2;
   logic [31:0]          r_p;
   logic signed [31:0]   w_i_ext, w_q_ext;

   logic [WIN_LOG2-1:0]  r_cnt;
   logic [31:0]          r_peak_acc;
   logic [31:0]          r_power_peak;
   logic                 r_abs_ena;
   logic [31:0]          w_peak_max;

   assign w_i_ext = 32'(r_i);
   assign w_q_ext = 32'(r_q);

   // Squares of a 16-bit signed value never exceed 2^30, so 31 bits hold them and
   // their sum (max 2^31) fits 32 bits unsigned without saturation.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vld0 <= 1'b0;
         r_vld1 <= 1'b0;
         r_vld2 <= 1'b0;
         r_i    <= '0;
         r_q    <= '0;
         r_i2   <= '0;
         r_q2   <= '0;
         r_p    <= '0;
      end else begin
         r_vld0 <= i_data_vld & ~i_clr;
         r_vld1 <= r_vld0 & ~i_clr;
         r_vld2 <= r_vld1 & ~i_clr;
         r_i    <= i_data_i;
         r_q    <= i_data_q;
         r_i2   <= 31'(w_i_ext * w_i_ext);
         r_q2   <= 31'(w_q_ext * w_q_ext);
         r_p    <= 32'(r_i2) + 32'(r_q2);
      end
   end

   assign w_peak_max = (r_p > r_peak_acc) ? r_p : r_peak_acc;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   // Window closes on the last valid power sample; a coincident clear suppresses it.
   always_comb begin
      w_state_n = r_state;
      w_close   = 1'b0;
      if (r_vld2) begin
         case (r_state)
            S_IDLE: w_state_n = S_ACC;
            S_ACC: begin
               if (r_cnt == CNT_MAX) begin
                  w_close   = 1'b1;
                  w_state_n = S_IDLE;
               end
            end
            default: w_state_n = S_IDLE;
         endcase
      end
      if (i_clr) begin
         w_state_n = S_IDLE;
         w_close   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt        <= '0;
         r_peak_acc   <= '0;
         r_power_peak <= '0;
         r_abs_ena    <= 1'b0;
      end else begin
         r_abs_ena <= w_close;
         if (i_clr) begin
            r_cnt      <= '0;
            r_peak_acc <= '0;
         end else if (r_vld2) begin
            // Counter wraps to zero on the closing sample.
            r_cnt      <= r_cnt + 1'b1;
            // First sample of a window loads directly, discarding the old peak.
            r_peak_acc <= (r_state == S_IDLE) ? r_p : w_peak_max;
            if (w_close) begin
               r_power_peak <= w_peak_max;
            end
         end
      end
   end

`ifdef AGC_MEAN_POWER_EN
   logic [47:0] r_sum;
   logic [47:0] w_sum_next;
   logic [31:0] r_power_mean;

   assign w_sum_next = r_sum + 48'(r_p);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sum        <= '0;
         r_power_mean <= '0;
      end else begin
         if (i_clr) begin
            r_sum <= '0;
         end else if (r_vld2) begin
            r_sum <= (r_state == S_IDLE) ? 48'(r_p) : w_sum_next;
            if (w_close) begin
               r_power_mean <= 32'(w_sum_next >> WIN_LOG2);
            end
         end
      end
   end

   assign o_power_mean = r_power_mean;
`else
   assign o_power_mean = 32'd0;
`endif

   assign o_power_peak = r_power_peak;
   assign o_abs_ena    = r_abs_ena;
   assign o_win_cnt    = 16'(r_cnt);

endmodule

// File: tb/tb_agc_power_peak_detect.sv
// tb/tb_agc_power_peak_detect.sv - directed self-checking bench for agc_power_peak_detect
module tb_agc_power_peak_detect;

   localparam int WIN_LOG2 = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               clr;
   logic               vld;
   logic signed [15:0] di;
   logic signed [15:0] dq;
   logic [31:0]        o_power_peak;
   logic [31:0]        o_power_mean;
   logic               o_abs_ena;
   logic [15:0]        o_win_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] pk_q[$];
   logic [31:0] mn_q[$];
   int          cyc_q[$];

   agc_power_peak_detect #(.WIN_LOG2(WIN_LOG2), .DW(16)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_clr        (clr),
      .i_data_vld   (vld),
      .i_data_i     (di),
      .i_data_q     (dq),
      .o_power_peak (o_power_peak),
      .o_power_mean (o_power_mean),
      .o_abs_ena    (o_abs_ena),
      .o_win_cnt    (o_win_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_abs_ena === 1'b1) begin
         pk_q.push_back(o_power_peak);
         mn_q.push_back(o_power_mean);
         cyc_q.push_back(cyc);
      end
   end

   function automatic logic [31:0] exp_mean(input logic [31:0] v);
`ifdef AGC_MEAN_POWER_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   task automatic drive(input logic v, input int i, input int q);
      vld = v;
      di  = 16'(i);
      dq  = 16'(q);
      @(posedge clk);
      #1;
   endtask

   task automatic flush_q;
      pk_q.delete();
      mn_q.delete();
      cyc_q.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1; clr = 1'b0; vld = 1'b0; di = '0; dq = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (o_power_peak !== 32'd0) begin failures++; $display("FAIL reset_peak got=%0d exp=0", o_power_peak); end
      checks++; if (o_power_mean !== 32'd0) begin failures++; $display("FAIL reset_mean got=%0d exp=0", o_power_mean); end
      checks++; if (o_abs_ena !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%0b exp=0", o_abs_ena); end
      checks++; if (o_win_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", o_win_cnt); end
      rst = 1'b0;
      drive(1'b0, 0, 0);
   endtask

   task automatic test_basic;
      flush_q();
      repeat (4) drive(1'b1, 1000, 1000);
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 0, 0);
         checks++;
         if (o_abs_ena !== (k == 3)) begin
            failures++; $display("FAIL basic_latency k=%0d got=%0b exp=%0b", k, o_abs_ena, (k == 3));
         end
         if (k == 3) begin
            checks++; if (o_power_peak !== 32'd2000000) begin failures++; $display("FAIL basic_peak got=%0d exp=2000000", o_power_peak); end
            checks++; if (o_power_mean !== exp_mean(32'd2000000)) begin failures++; $display("FAIL basic_mean got=%0d exp=%0d", o_power_mean, exp_mean(32'd2000000)); end
         end
      end
      checks++; if (pk_q.size() != 1) begin failures++; $display("FAIL basic_strobe_count got=%0d exp=1", pk_q.size()); end
   endtask

   task automatic test_extreme;
      flush_q();
      drive(1'b1, -32768, -32768);
      repeat (3) drive(1'b1, 0, 0);
      repeat (4) drive(1'b0, 0, 0);
      checks++;
      if (pk_q.size() != 1) begin
         failures++; $display("FAIL extreme_strobe_count got=%0d exp=1", pk_q.size());
      end else begin
         checks++; if (pk_q[0] !== 32'h8000_0000) begin failures++; $display("FAIL extreme_peak got=%h exp=80000000", pk_q[0]); end
         checks++; if (mn_q[0] !== exp_mean(32'h2000_0000)) begin failures++; $display("FAIL extreme_mean got=%h exp=%h", mn_q[0], exp_mean(32'h2000_0000)); end
      end
   endtask

   task automatic test_back_to_back;
      flush_q();
      repeat (4) drive(1'b1, 500, 500);
      repeat (4) drive(1'b1, 10, 10);
      repeat (5) drive(1'b0, 0, 0);
      checks++;
      if (pk_q.size() != 2) begin
         failures++; $display("FAIL b2b_strobe_count got=%0d exp=2", pk_q.size());
      end else begin
         checks++; if (pk_q[0] !== 32'd500000) begin failures++; $display("FAIL b2b_peak1 got=%0d exp=500000", pk_q[0]); end
         checks++; if (pk_q[1] !== 32'd200) begin failures++; $display("FAIL b2b_peak2 got=%0d exp=200", pk_q[1]); end
         checks++; if (mn_q[1] !== exp_mean(32'd200)) begin failures++; $display("FAIL b2b_mean2 got=%0d exp=%0d", mn_q[1], exp_mean(32'd200)); end
         checks++; if (cyc_q[1] - cyc_q[0] != 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", cyc_q[1] - cyc_q[0]); end
      end
   endtask

   task automatic test_gaps;
      int pat[12] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
      int vals[6] = '{30, 70, 50, 20, 40, 60};
      int vi    = 0;
      int nproc = 0;
      flush_q();
      for (int j = 0; j < 12; j++) begin
         if (pat[j] == 1) begin
            drive(1'b1, vals[vi], vals[vi]);
            vi++;
         end else begin
            drive(1'b0, 0, 0);
         end
         if (j >= 3 && pat[j-3] == 1) nproc++;
         checks++;
         if (o_win_cnt !== 16'(nproc % 4)) begin
            failures++; $display("FAIL gaps_win_cnt j=%0d got=%0d exp=%0d", j, o_win_cnt, nproc % 4);
         end
      end
      checks++;
      if (pk_q.size() != 1) begin
         failures++; $display("FAIL gaps_strobe_count got=%0d exp=1", pk_q.size());
      end else begin
         checks++; if (pk_q[0] !== 32'd9800) begin failures++; $display("FAIL gaps_peak got=%0d exp=9800", pk_q[0]); end
         checks++; if (mn_q[0] !== exp_mean(32'd4350)) begin failures++; $display("FAIL gaps_mean got=%0d exp=%0d", mn_q[0], exp_mean(32'd4350)); end
      end
      clr = 1'b1;
      drive(1'b0, 0, 0);
      clr = 1'b0;
      checks++; if (o_win_cnt !== 16'd0) begin failures++; $display("FAIL gaps_clr_cnt got=%0d exp=0", o_win_cnt); end
   endtask

   task automatic test_clear;
      flush_q();
      repeat (4) drive(1'b1, 7, 7);
      repeat (2) drive(1'b0, 0, 0);
      clr = 1'b1;
      drive(1'b0, 0, 0);
      clr = 1'b0;
      checks++; if (o_abs_ena !== 1'b0) begin failures++; $display("FAIL clr_strobe got=%0b exp=0", o_abs_ena); end
      checks++; if (o_power_peak !== 32'd9800) begin failures++; $display("FAIL clr_peak_hold got=%0d exp=9800", o_power_peak); end
      checks++; if (o_power_mean !== exp_mean(32'd4350)) begin failures++; $display("FAIL clr_mean_hold got=%0d exp=%0d", o_power_mean, exp_mean(32'd4350)); end
      checks++; if (o_win_cnt !== 16'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", o_win_cnt); end
      repeat (3) drive(1'b0, 0, 0);
      checks++; if (pk_q.size() != 0) begin failures++; $display("FAIL clr_no_strobe got=%0d exp=0", pk_q.size()); end
      repeat (4) drive(1'b1, 3, 3);
      repeat (4) drive(1'b0, 0, 0);
      checks++;
      if (pk_q.size() != 1) begin
         failures++; $display("FAIL clr_next_count got=%0d exp=1", pk_q.size());
      end else begin
         checks++; if (pk_q[0] !== 32'd18) begin failures++; $display("FAIL clr_next_peak got=%0d exp=18", pk_q[0]); end
         checks++; if (mn_q[0] !== exp_mean(32'd18)) begin failures++; $display("FAIL clr_next_mean got=%0d exp=%0d", mn_q[0], exp_mean(32'd18)); end
      end
   endtask

   task automatic test_async_reset;
      flush_q();
      repeat (2) drive(1'b1, 100, 100);
      drive(1'b0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (o_power_peak !== 32'd0) begin failures++; $display("FAIL arst_peak got=%0d exp=0", o_power_peak); end
      checks++; if (o_power_mean !== 32'd0) begin failures++; $display("FAIL arst_mean got=%0d exp=0", o_power_mean); end
      checks++; if (o_win_cnt !== 16'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", o_win_cnt); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      repeat (6) drive(1'b0, 0, 0);
      checks++; if (pk_q.size() != 0) begin failures++; $display("FAIL arst_no_partial got=%0d exp=0", pk_q.size()); end
      repeat (4) drive(1'b1, 5, 5);
      repeat (4) drive(1'b0, 0, 0);
      checks++;
      if (pk_q.size() != 1) begin
         failures++; $display("FAIL arst_next_count got=%0d exp=1", pk_q.size());
      end else begin
         checks++; if (pk_q[0] !== 32'd50) begin failures++; $display("FAIL arst_next_peak got=%0d exp=50", pk_q[0]); end
         checks++; if (mn_q[0] !== exp_mean(32'd50)) begin failures++; $display("FAIL arst_next_mean got=%0d exp=%0d", mn_q[0], exp_mean(32'd50)); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extreme();
      test_back_to_back();
      test_gaps();
      test_clear();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
